// File: rtl/key_event_scheduler_pkg.sv
// Shared key-event types and default sizing for the keyboard front end.
package asicle_keys_pkg;

  localparam int INPUTS_DEFAULT = 32;
  localparam int KEY_W_DEFAULT  = $clog2(INPUTS_DEFAULT);

  typedef enum logic [1:0] {
    EV_PRESS   = 2'd0,
    EV_RELEASE = 2'd1,
    EV_REPEAT  = 2'd2
  } ev_kind_t;

endpackage

// File: rtl/key_event_scheduler_rr_find_first.sv
// Round-robin search: first set request at or after start, wrapping modulo N.
module rr_find_first #(
  parameter int N = 32,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);

  // Walk the rotated vector from its far end so the lowest rotated offset wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(start) + i) % N]) begin
        found = 1'b1;
        idx   = W'((int'(start) + i) % N);
      end
    end
  end

endmodule

// File: rtl/key_event_scheduler.sv
// Serialises debounced key pulses into one PRESS/RELEASE/REPEAT event per
// valid/ready handshake, round-robin across keys, with typematic auto-repeat.
module key_event_scheduler
  import asicle_keys_pkg::*;
#(
  parameter int INPUTS       = INPUTS_DEFAULT,
  parameter int REPEAT_DELAY = 24,
  parameter int REPEAT_RATE  = 6,
  parameter int CNT_W        = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [INPUTS-1:0]         held_down,
  input  logic [INPUTS-1:0]         just_pressed,
  input  logic [INPUTS-1:0]         just_released,
  input  logic                      tick,
  input  logic                      ev_ready,
  output logic                      ev_valid,
  output logic [$clog2(INPUTS)-1:0] ev_code,
  output logic [1:0]                ev_kind,
  output logic                      overflow,
  input  logic                      clear_overflow
);

  localparam int CODE_W = $clog2(INPUTS);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  localparam logic [CODE_W-1:0] LAST_KEY = CODE_W'(INPUTS - 1);
  localparam logic [CNT_W-1:0]  DELAY_LD = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0]  RATE_LD  = CNT_W'(REPEAT_RATE);

  logic [0:0]        state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  ev_kind_t          kind_q, kind_d;
  logic [CODE_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [INPUTS-1:0] pend_press_q, pend_press_d;
  logic [INPUTS-1:0] pend_release_q, pend_release_d;
  logic [INPUTS-1:0] pend_repeat_q, pend_repeat_d;
  logic              rpt_active_q, rpt_active_d;
  logic [CODE_W-1:0] rpt_key_q, rpt_key_d;
  logic [CNT_W-1:0]  rpt_cnt_q, rpt_cnt_d;
  logic              overflow_q, overflow_d;

  logic [INPUTS-1:0] take_press, take_release, take_repeat;
  logic              found;
  logic [CODE_W-1:0] found_idx;
  logic [CODE_W-1:0] new_key;
  logic              ovf_pulse, ovf_repeat;

  rr_find_first #(
    .N (INPUTS),
    .W (CODE_W)
  ) u_rr_find_first (
    .req   (pend_press_q | pend_release_q | pend_repeat_q),
    .start (rr_ptr_q),
    .found (found),
    .idx   (found_idx)
  );

  // Event presentation: pick one pending bit in IDLE, hold it until accepted.
  always_comb begin
    // NOTE: every signal this block drives gets a default first, so no branch can leave one unassigned and infer a latch.
    state_d      = state_q;
    code_d       = code_q;
    kind_d       = kind_q;
    rr_ptr_d     = rr_ptr_q;
    take_press   = '0;
    take_release = '0;
    take_repeat  = '0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_PRESENT;
          code_d  = found_idx;
          // With both edges pending, the current level tells which edge happened first.
          if (pend_press_q[found_idx] &&
              (!pend_release_q[found_idx] || !held_down[found_idx])) begin
            kind_d                = EV_PRESS;
            take_press[found_idx] = 1'b1;
          end else if (pend_release_q[found_idx]) begin
            kind_d                  = EV_RELEASE;
            take_release[found_idx] = 1'b1;
          end else begin
            kind_d                 = EV_REPEAT;
            take_repeat[found_idx] = 1'b1;
          end
        end
      end
      default: begin
        if (ev_ready) begin
          state_d  = ST_IDLE;
          rr_ptr_d = (code_q == LAST_KEY) ? '0 : code_q + CODE_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    new_key = '0;
    for (int i = 0; i < INPUTS; i++) begin
      if (just_pressed[i]) new_key = CODE_W'(i);
    end
  end

  // Typematic tracker: a fresh press always restarts on the highest pressed key.
  always_comb begin
    rpt_active_d  = rpt_active_q;
    rpt_key_d     = rpt_key_q;
    rpt_cnt_d     = rpt_cnt_q;
    pend_repeat_d = pend_repeat_q & ~take_repeat;
    ovf_repeat    = 1'b0;
    if (|just_pressed) begin
      rpt_active_d  = 1'b1;
      rpt_key_d     = new_key;
      rpt_cnt_d     = DELAY_LD;
      pend_repeat_d = '0;
    end else if (rpt_active_q) begin
      if (just_released[rpt_key_q] || !held_down[rpt_key_q]) begin
        rpt_active_d             = 1'b0;
        pend_repeat_d[rpt_key_q] = 1'b0;
      end else if (tick) begin
        if (rpt_cnt_q <= CNT_W'(1)) begin
          ovf_repeat               = pend_repeat_d[rpt_key_q];
          pend_repeat_d[rpt_key_q] = 1'b1;
          rpt_cnt_d                = RATE_LD;
        end else begin
          rpt_cnt_d = rpt_cnt_q - CNT_W'(1);
        end
      end
    end
  end

  // New pulses win over a same-cycle consume; only a hit on a resting bit is lost.
  always_comb begin
    pend_press_d   = (pend_press_q & ~take_press) | just_pressed;
    pend_release_d = (pend_release_q & ~take_release) | just_released;
    ovf_pulse      = |((just_pressed & pend_press_q & ~take_press) |
                       (just_released & pend_release_q & ~take_release));
    overflow_d     = (overflow_q & ~clear_overflow) | ovf_pulse | ovf_repeat;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      code_q         <= '0;
      kind_q         <= EV_PRESS;
      rr_ptr_q       <= '0;
      pend_press_q   <= '0;
      pend_release_q <= '0;
      pend_repeat_q  <= '0;
      rpt_active_q   <= 1'b0;
      rpt_key_q      <= '0;
      rpt_cnt_q      <= '0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      code_q         <= code_d;
      kind_q         <= kind_d;
      rr_ptr_q       <= rr_ptr_d;
      pend_press_q   <= pend_press_d;
      pend_release_q <= pend_release_d;
      pend_repeat_q  <= pend_repeat_d;
      rpt_active_q   <= rpt_active_d;
      rpt_key_q      <= rpt_key_d;
      rpt_cnt_q      <= rpt_cnt_d;
      overflow_q     <= overflow_d;
    end
  end

  assign ev_valid = (state_q == ST_PRESENT);
  assign ev_code  = code_q;
  assign ev_kind  = kind_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_key_event_scheduler.sv
// Scoreboard bench: an event-level model pushes expected events, a monitor pops on each handshake.
module tb_key_event_scheduler;
  import asicle_keys_pkg::*;

  localparam int N     = 32;
  localparam int DELAY = 3;
  localparam int RATE  = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] held_down = '0;
  logic [N-1:0] just_pressed = '0;
  logic [N-1:0] just_released = '0;
  logic         tick = 1'b0;
  logic         ev_ready = 1'b0;
  logic         clear_overflow = 1'b0;
  logic         ev_valid;
  logic [4:0]   ev_code;
  logic [1:0]   ev_kind;
  logic         overflow;

  always #5 clk = ~clk;

  key_event_scheduler #(
    .INPUTS       (N),
    .REPEAT_DELAY (DELAY),
    .REPEAT_RATE  (RATE),
    .CNT_W        (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .held_down      (held_down),
    .just_pressed   (just_pressed),
    .just_released  (just_released),
    .tick           (tick),
    .ev_ready       (ev_ready),
    .ev_valid       (ev_valid),
    .ev_code        (ev_code),
    .ev_kind        (ev_kind),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  typedef struct {
    int code;
    int kind;
  } ev_t;

  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];

  // Model state: pending edges per key, next search start, held levels, sticky loss flag.
  bit [N-1:0] m_press = '0;
  bit [N-1:0] m_rel = '0;
  bit [N-1:0] m_hd = '0;
  int         m_ptr = 0;
  bit         m_presented = 1'b0;
  bit         m_ovf = 1'b0;

  logic       mon_pv = 1'b0;
  logic       mon_pr = 1'b0;
  logic [4:0] mon_pc = '0;
  logic [1:0] mon_pk = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] bitv(input int k);
    bitv    = '0;
    bitv[k] = 1'b1;
  endfunction

  function automatic void push_exp(input int code, input int kind);
    ev_t e;
    e.code = code;
    e.kind = kind;
    exp_q.push_back(e);
    m_ptr = (code + 1) % N;
  endfunction

  // Next event in round-robin order; both edges pending -> current level says which came first.
  function automatic bit model_pick();
    for (int off = 0; off < N; off++) begin
      int k;
      k = (m_ptr + off) % N;
      if (m_press[k] || m_rel[k]) begin
        if (m_press[k] && (!m_rel[k] || !m_hd[k])) begin
          m_press[k] = 1'b0;
          push_exp(k, EV_PRESS);
        end else begin
          m_rel[k] = 1'b0;
          push_exp(k, EV_RELEASE);
        end
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic drive_pulse(input logic [N-1:0] pv, input logic [N-1:0] rv, input logic [N-1:0] hd);
    @(posedge clk); #1;
    just_pressed  = pv;
    just_released = rv;
    held_down     = hd;
    if (|((pv & m_press) | (rv & m_rel))) m_ovf = 1'b1;
    m_press |= pv;
    m_rel   |= rv;
    m_hd     = hd;
    if (!m_presented) m_presented = model_pick();
    @(posedge clk); #1;
    just_pressed  = '0;
    just_released = '0;
    repeat (2) @(posedge clk);
  endtask

  task automatic drain();
    while (model_pick()) begin end
    m_presented = 1'b0;
    for (int c = 0; c < 3000 && exp_q.size() > 0; c++) begin
      @(posedge clk); #1;
      ev_ready = ($urandom_range(0, 3) != 0);
    end
    check("drain_left", exp_q.size(), 0);
    ev_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_drain", ev_valid, 1'b0);
  endtask

  task automatic clear_ovf();
    @(posedge clk); #1;
    clear_overflow = 1'b1;
    @(posedge clk); #1;
    clear_overflow = 1'b0;
    m_ovf = 1'b0;
    check("overflow_clear", overflow, 1'b0);
  endtask

  task automatic tick_period();
    repeat (9) @(posedge clk);
    #1;
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
  endtask

  // Monitor: hold-stability while stalled, scoreboard compare on every handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_pv = 1'b0;
        continue;
      end
      if (ev_valid && mon_pv && !mon_pr) begin
        check("hold_code", ev_code, mon_pc);
        check("hold_kind", ev_kind, mon_pk);
      end
      if (ev_valid && ev_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got code %0d kind %0d expected none at %0t",
                   ev_code, ev_kind, $time);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("ev_code", ev_code, e.code);
          check("ev_kind", ev_kind, e.kind);
        end
      end
      mon_pv = ev_valid;
      mon_pr = ev_ready;
      mon_pc = ev_code;
      mon_pk = ev_kind;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    check("rst_ev_valid", ev_valid, 1'b0);
    check("rst_ev_code", ev_code, 5'd0);
    check("rst_ev_kind", ev_kind, 2'd0);
    check("rst_overflow", overflow, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset while an event is stalled and overflow is set.
    drive_pulse(bitv(4), '0, '0);
    drive_pulse(bitv(6), '0, '0);
    drive_pulse(bitv(6), '0, '0);
    check("pre_reset_valid", ev_valid, 1'b1);
    check("pre_reset_overflow", overflow, m_ovf);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", ev_valid, 1'b0);
    check("async_rst_overflow", overflow, 1'b0);
    exp_q.delete();
    m_press = '0; m_rel = '0; m_ptr = 0; m_presented = 1'b0; m_ovf = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ev_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("no_stale_event", ev_valid, 1'b0);
    ev_ready = 1'b0;

    // Keys 0 and 3 together with ready high: latency and order.
    @(posedge clk); #1;
    ev_ready     = 1'b1;
    just_pressed = 32'h0000_0009;
    m_press     |= 32'h0000_0009;
    m_hd         = '0;
    m_presented  = model_pick();
    @(posedge clk); #1;
    just_pressed = '0;
    check("latency_n1_valid", ev_valid, 1'b0);
    @(posedge clk); #1;
    check("latency_n2_valid", ev_valid, 1'b1);
    check("latency_n2_code", ev_code, 5'd0);
    drain();
    drive_pulse(bitv(2) | bitv(5), '0, '0);
    drain();

    // Same key pressed and released while blocked, both orders.
    drive_pulse(bitv(0), '0, '0);
    drive_pulse(bitv(5), '0, bitv(5));
    drive_pulse('0, bitv(5), '0);
    drain();
    drive_pulse(bitv(0), '0, '0);
    drive_pulse('0, bitv(5), '0);
    drive_pulse(bitv(5), '0, bitv(5));
    drain();

    // Typematic repeat on key 7; the press lands on a tick, which must not count.
    ev_ready = 1'b1;
    @(posedge clk); #1;
    just_pressed = bitv(7);
    held_down    = bitv(7);
    tick         = 1'b1;
    push_exp(7, EV_PRESS);
    @(posedge clk); #1;
    just_pressed = '0;
    tick         = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      if (t == DELAY || (t > DELAY && (t - DELAY) % RATE == 0)) push_exp(7, EV_REPEAT);
      tick_period();
    end
    repeat (9) @(posedge clk);
    #1;
    just_released = bitv(7);
    held_down     = '0;
    push_exp(7, EV_RELEASE);
    @(posedge clk); #1;
    just_released = '0;
    for (int t = 0; t < 4; t++) tick_period();
    repeat (4) @(posedge clk);
    #1;
    check("repeat_all_seen", exp_q.size(), 0);
    ev_ready = 1'b0;

    // Repeat expiring twice during a stall: one REPEAT kept, overflow flagged.
    @(posedge clk); #1;
    just_pressed = bitv(7);
    held_down    = bitv(7);
    push_exp(7, EV_PRESS);
    @(posedge clk); #1;
    just_pressed = '0;
    for (int t = 0; t < DELAY + RATE; t++) tick_period();
    repeat (3) @(posedge clk);
    #1;
    check("repeat_overflow", overflow, 1'b1);
    push_exp(7, EV_REPEAT);
    m_hd = bitv(7);
    drain();
    drive_pulse('0, bitv(7), '0);
    drain();
    clear_ovf();

    // Double pulse on a resting pending bit, then a pulse on the consume cycle.
    drive_pulse(bitv(9), '0, '0);
    drive_pulse(bitv(2), '0, '0);
    check("no_ovf_single", overflow, 1'b0);
    drive_pulse(bitv(2), '0, '0);
    check("ovf_double", overflow, m_ovf);
    clear_ovf();
    @(posedge clk); #1;
    ev_ready = 1'b1;
    @(posedge clk); #1;
    ev_ready     = 1'b0;
    just_pressed = bitv(2);
    void'(model_pick());
    m_press[2]  = 1'b1;
    m_presented = 1'b1;
    @(posedge clk); #1;
    just_pressed = '0;
    drain();
    check("ovf_coincide", overflow, 1'b0);

    // Pointer at 31 with keys 1, 30, 31 pending exercises wrap-around.
    drive_pulse(bitv(30), '0, '0);
    drive_pulse(bitv(1) | bitv(30) | bitv(31), '0, '0);
    drain();

    // Randomised bursts of presses and releases against the event-level model.
    for (int p = 0; p < 40; p++) begin
      logic [N-1:0] hd;
      int           np;
      hd = $urandom;
      np = $urandom_range(1, 3);
      for (int i = 0; i < np; i++) begin
        drive_pulse($urandom & $urandom & $urandom, $urandom & $urandom & $urandom, hd);
      end
      drain();
      check("overflow_rand", overflow, m_ovf);
      clear_ovf();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
